// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcodes, IR field positions,
// FSM states and the opcode-to-instruction-class decode.
package cpu_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU3, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY,
    C_BR, C_JR, C_NOP, C_HALT, C_ILL
  } iclass_e;

  function automatic iclass_e classify(input logic [4:0] op);
    iclass_e c;
    if (op == OP_LD)                            c = C_LD;
    else if (op == OP_LDI)                      c = C_LDI;
    else if (op == OP_ST)                       c = C_ST;
    else if (op >= OP_ADD && op <= OP_SHL)      c = C_ALU3;
    else if (op >= OP_ADDI && op <= OP_ORI)     c = C_IMM;
    else if (op == OP_DIV || op == OP_MUL)      c = C_MULDIV;
    else if (op == OP_NEG || op == OP_NOT)      c = C_UNARY;
    else if (op == OP_BR)                       c = C_BR;
    else if (op == OP_JR)                       c = C_JR;
    else if (op == OP_NOP)                      c = C_NOP;
    else if (op == OP_HALT)                     c = C_HALT;
    else                                        c = C_ILL;
    return c;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Strobe bundle between the control sequencer (master) and the bus datapath (slave).
interface control_sequencer_if #(
  parameter int NUM_REGS = 16
);
  logic                run;
  logic [31:0]         ir;
  logic                con_ff;

  logic                PCout, ZLowout, ZHighout, MDRout, Cout;
  logic                MAR_enable, Z_low_enable, Z_high_enable, PC_enable, MDR_enable;
  logic                IR_enable, Y_enable, HI_enable, LO_enable, CON_enable;
  logic                IncPC, Read, Write, BAout;
  logic [4:0]          operation;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic                halted;
  logic                illegal;

  modport master (
    input  run, ir, con_ff,
    output PCout, ZLowout, ZHighout, MDRout, Cout,
           MAR_enable, Z_low_enable, Z_high_enable, PC_enable, MDR_enable,
           IR_enable, Y_enable, HI_enable, LO_enable, CON_enable,
           IncPC, Read, Write, BAout, operation, reg_in, reg_out, halted, illegal
  );

  modport slave (
    output run, ir, con_ff,
    input  PCout, ZLowout, ZHighout, MDRout, Cout,
           MAR_enable, Z_low_enable, Z_high_enable, PC_enable, MDR_enable,
           IR_enable, Y_enable, HI_enable, LO_enable, CON_enable,
           IncPC, Read, Write, BAout, operation, reg_in, reg_out, halted, illegal
  );
endinterface

// File: rtl/control_sequencer_select_encode.sv
// Picks the Ra/Rb/Rc field of IR and expands it into one-hot GPR in/out strobes.
module select_encode
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [31:0]         ir,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                baout,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out
);

  logic [3:0]          field;
  logic [NUM_REGS-1:0] onehot;
  logic                unused_ir;

  assign unused_ir = ^{ir[OPC_HI:OPC_LO], ir[RC_LO-1:0]};

  always_comb begin
    field = '0;
    if (gra)      field = ir[RA_HI:RA_LO];
    else if (grb) field = ir[RB_HI:RB_LO];
    else if (grc) field = ir[RC_HI:RC_LO];
    onehot        = '0;
    onehot[field] = 1'b1;
    reg_in        = rin ? onehot : '0;
    // BAout still addresses the Rb field: the register file substitutes zero for R0.
    reg_out       = (rout || baout) ? onehot : '0;
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: fetch, then an opcode-specific execute sequence,
// driving every datapath strobe as a Moore decode of state and IR.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int NUM_REGS = 16
) (
  input  logic clock,
  input  logic clear,
  control_sequencer_if.master bus
);

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       gra, grb, grc, rin, rout, done, wait_done;
  logic [4:0] opcode;
  iclass_e    cls;

  assign opcode    = bus.ir[OPC_HI:OPC_LO];
  assign cls       = classify(opcode);
  assign wait_done = (wait_q == 3'(MEM_WAIT));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    wait_d            = '0;
    done              = 1'b0;
    gra               = 1'b0;
    grb               = 1'b0;
    grc               = 1'b0;
    rin               = 1'b0;
    rout              = 1'b0;
    bus.PCout         = 1'b0;
    bus.ZLowout       = 1'b0;
    bus.ZHighout      = 1'b0;
    bus.MDRout        = 1'b0;
    bus.Cout          = 1'b0;
    bus.MAR_enable    = 1'b0;
    bus.Z_low_enable  = 1'b0;
    bus.Z_high_enable = 1'b0;
    bus.PC_enable     = 1'b0;
    bus.MDR_enable    = 1'b0;
    bus.IR_enable     = 1'b0;
    bus.Y_enable      = 1'b0;
    bus.HI_enable     = 1'b0;
    bus.LO_enable     = 1'b0;
    bus.CON_enable    = 1'b0;
    bus.IncPC         = 1'b0;
    bus.Read          = 1'b0;
    bus.Write         = 1'b0;
    bus.BAout         = 1'b0;
    bus.operation     = '0;
    bus.illegal       = 1'b0;
    bus.halted        = (state_q == S_HALT);

    case (state_q)
      S_IDLE: if (bus.run) state_d = S_F0;
      S_F0: begin
        bus.PCout = 1'b1; bus.MAR_enable = 1'b1; bus.IncPC = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        bus.Read = 1'b1; bus.MDR_enable = 1'b1;
        if (wait_done) state_d = S_F2;
        else           wait_d  = wait_q + 3'd1;
      end
      // nop/halt dispatch here: ir already presents the word being loaded into IR.
      S_F2: begin
        bus.MDRout = 1'b1; bus.IR_enable = 1'b1;
        if (cls == C_NOP)       done    = 1'b1;
        else if (cls == C_HALT) state_d = S_HALT;
        else                    state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T4;
        case (cls)
          C_ALU3, C_IMM:     begin grb = 1'b1; rout = 1'b1; bus.Y_enable = 1'b1; end
          C_LDI, C_LD, C_ST: begin grb = 1'b1; bus.BAout = 1'b1; bus.Y_enable = 1'b1; end
          C_MULDIV:          begin gra = 1'b1; rout = 1'b1; bus.Y_enable = 1'b1; end
          C_UNARY: begin
            grb = 1'b1; rout = 1'b1; bus.operation = opcode; bus.Z_low_enable = 1'b1;
          end
          C_BR:    begin gra = 1'b1; rout = 1'b1; bus.CON_enable = 1'b1; end
          C_JR:    begin gra = 1'b1; rout = 1'b1; bus.PC_enable = 1'b1; done = 1'b1; end
          default: begin bus.illegal = (cls == C_ILL); done = 1'b1; end
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (cls)
          C_ALU3: begin
            grc = 1'b1; rout = 1'b1; bus.operation = opcode; bus.Z_low_enable = 1'b1;
          end
          C_IMM:             begin bus.Cout = 1'b1; bus.operation = opcode; bus.Z_low_enable = 1'b1; end
          C_LDI, C_LD, C_ST: begin bus.Cout = 1'b1; bus.operation = OP_ADD; bus.Z_low_enable = 1'b1; end
          C_MULDIV: begin
            grb = 1'b1; rout = 1'b1; bus.operation = opcode;
            bus.Z_low_enable = 1'b1; bus.Z_high_enable = 1'b1;
          end
          C_UNARY: begin bus.ZLowout = 1'b1; gra = 1'b1; rin = 1'b1; done = 1'b1; end
          C_BR:    begin bus.PCout = 1'b1; bus.Y_enable = 1'b1; end
          default: done = 1'b1;
        endcase
      end
      S_T5: begin
        state_d = S_T6;
        case (cls)
          C_ALU3, C_IMM, C_LDI: begin bus.ZLowout = 1'b1; gra = 1'b1; rin = 1'b1; done = 1'b1; end
          C_LD, C_ST: begin bus.ZLowout = 1'b1; bus.MAR_enable = 1'b1; end
          C_MULDIV:   begin bus.ZLowout = 1'b1; bus.LO_enable = 1'b1; end
          C_BR:       begin bus.Cout = 1'b1; bus.operation = OP_ADD; bus.Z_low_enable = 1'b1; end
          default:    done = 1'b1;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD: begin
            bus.Read = 1'b1; bus.MDR_enable = 1'b1;
            if (wait_done) state_d = S_T7;
            else           wait_d  = wait_q + 3'd1;
          end
          C_ST:     begin gra = 1'b1; rout = 1'b1; bus.MDR_enable = 1'b1; state_d = S_T7; end
          C_MULDIV: begin bus.ZHighout = 1'b1; bus.HI_enable = 1'b1; done = 1'b1; end
          // The only Mealy term: the branch is taken on the live condition flag.
          C_BR:     begin bus.ZLowout = 1'b1; bus.PC_enable = bus.con_ff; done = 1'b1; end
          default:  done = 1'b1;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin bus.MDRout = 1'b1; gra = 1'b1; rin = 1'b1; done = 1'b1; end
          C_ST: begin
            bus.Write = 1'b1;
            if (wait_done) done   = 1'b1;
            else           wait_d = wait_q + 3'd1;
          end
          default: done = 1'b1;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (done) state_d = bus.run ? S_F0 : S_IDLE;
  end

  select_encode #(.NUM_REGS(NUM_REGS)) u_select_encode (
    .ir      (bus.ir),
    .gra     (gra),
    .grb     (grb),
    .grc     (grc),
    .rin     (rin),
    .rout    (rout),
    .baout   (bus.BAout),
    .reg_in  (bus.reg_in),
    .reg_out (bus.reg_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised instruction streams checked cycle by cycle against a step-list model
// of each instruction; two sequencers cover MEM_WAIT = 0 and MEM_WAIT = 2.
module tb_control_sequencer;

  typedef struct packed {
    logic pcout, zlowout, zhighout, mdrout, cout;
    logic mar_en, zl_en, zh_en, pc_en, mdr_en, ir_en, y_en, hi_en, lo_en, con_en;
    logic incpc, read, write, baout;
    logic [4:0]  op;
    logic [15:0] rin, rout;
    logic halted, illegal;
  } outv_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        run_a [2];
  logic [31:0] ir_a  [2];
  logic        con_a [2];
  outv_t       obs   [2];
  outv_t       st_q[$];
  logic [32:0] pre_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  control_sequencer_if #(.NUM_REGS(16)) if0 ();
  control_sequencer_if #(.NUM_REGS(16)) if1 ();

  assign if0.run = run_a[0];  assign if0.ir = ir_a[0];  assign if0.con_ff = con_a[0];
  assign if1.run = run_a[1];  assign if1.ir = ir_a[1];  assign if1.con_ff = con_a[1];

  assign obs[0] = {if0.PCout, if0.ZLowout, if0.ZHighout, if0.MDRout, if0.Cout,
                   if0.MAR_enable, if0.Z_low_enable, if0.Z_high_enable, if0.PC_enable,
                   if0.MDR_enable, if0.IR_enable, if0.Y_enable, if0.HI_enable, if0.LO_enable,
                   if0.CON_enable, if0.IncPC, if0.Read, if0.Write, if0.BAout, if0.operation,
                   if0.reg_in, if0.reg_out, if0.halted, if0.illegal};
  assign obs[1] = {if1.PCout, if1.ZLowout, if1.ZHighout, if1.MDRout, if1.Cout,
                   if1.MAR_enable, if1.Z_low_enable, if1.Z_high_enable, if1.PC_enable,
                   if1.MDR_enable, if1.IR_enable, if1.Y_enable, if1.HI_enable, if1.LO_enable,
                   if1.CON_enable, if1.IncPC, if1.Read, if1.Write, if1.BAout, if1.operation,
                   if1.reg_in, if1.reg_out, if1.halted, if1.illegal};

  control_sequencer #(.MEM_WAIT(0), .NUM_REGS(16)) dut0 (.clock(clock), .clear(clear), .bus(if0));
  control_sequencer #(.MEM_WAIT(2), .NUM_REGS(16)) dut1 (.clock(clock), .clear(clear), .bus(if1));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] oh(input logic [3:0] n);
    return 16'(1) << n;
  endfunction

  task automatic check_vec(input string name, input outv_t got, input outv_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Expected per-cycle outputs of one instruction, fetch included, written straight
  // from the step tables; halt contributes only its fetch.
  task automatic build(input logic [31:0] w, input logic c, input int mw);
    outv_t s;
    int o;
    logic [3:0] ra, rb, rc;
    o = int'(w[31:27]); ra = w[26:23]; rb = w[22:19]; rc = w[18:15];
    st_q.delete();
    s = '0; s.pcout = 1; s.mar_en = 1; s.incpc = 1; st_q.push_back(s);
    repeat (mw + 1) begin s = '0; s.read = 1; s.mdr_en = 1; st_q.push_back(s); end
    s = '0; s.mdrout = 1; s.ir_en = 1; st_q.push_back(s);
    if ((o >= 3 && o <= 11) || (o >= 12 && o <= 14)) begin
      s = '0; s.rout = oh(rb); s.y_en = 1; st_q.push_back(s);
      s = '0; s.op = 5'(o); s.zl_en = 1;
      if (o <= 11) s.rout = oh(rc); else s.cout = 1;
      st_q.push_back(s);
      s = '0; s.zlowout = 1; s.rin = oh(ra); st_q.push_back(s);
    end else if (o <= 2) begin
      s = '0; s.rout = oh(rb); s.baout = 1; s.y_en = 1; st_q.push_back(s);
      s = '0; s.cout = 1; s.op = 5'd3; s.zl_en = 1; st_q.push_back(s);
      if (o == 1) begin
        s = '0; s.zlowout = 1; s.rin = oh(ra); st_q.push_back(s);
      end else begin
        s = '0; s.zlowout = 1; s.mar_en = 1; st_q.push_back(s);
        if (o == 0) begin
          repeat (mw + 1) begin s = '0; s.read = 1; s.mdr_en = 1; st_q.push_back(s); end
          s = '0; s.mdrout = 1; s.rin = oh(ra); st_q.push_back(s);
        end else begin
          s = '0; s.rout = oh(ra); s.mdr_en = 1; st_q.push_back(s);
          repeat (mw + 1) begin s = '0; s.write = 1; st_q.push_back(s); end
        end
      end
    end else if (o == 15 || o == 16) begin
      s = '0; s.rout = oh(ra); s.y_en = 1; st_q.push_back(s);
      s = '0; s.rout = oh(rb); s.op = 5'(o); s.zl_en = 1; s.zh_en = 1; st_q.push_back(s);
      s = '0; s.zlowout = 1; s.lo_en = 1; st_q.push_back(s);
      s = '0; s.zhighout = 1; s.hi_en = 1; st_q.push_back(s);
    end else if (o == 17 || o == 18) begin
      s = '0; s.rout = oh(rb); s.op = 5'(o); s.zl_en = 1; st_q.push_back(s);
      s = '0; s.zlowout = 1; s.rin = oh(ra); st_q.push_back(s);
    end else if (o == 19) begin
      s = '0; s.rout = oh(ra); s.con_en = 1; st_q.push_back(s);
      s = '0; s.pcout = 1; s.y_en = 1; st_q.push_back(s);
      s = '0; s.cout = 1; s.op = 5'd3; s.zl_en = 1; st_q.push_back(s);
      s = '0; s.zlowout = 1; s.pc_en = c; st_q.push_back(s);
    end else if (o == 20) begin
      s = '0; s.rout = oh(ra); s.pc_en = 1; st_q.push_back(s);
    end else if (o != 26 && o != 27) begin
      s = '0; s.illegal = 1; st_q.push_back(s);
    end
  endtask

  task automatic pick(output logic [31:0] w, output logic c);
    logic [4:0] opc;
    if (pre_q.size() > 0) begin
      {c, w} = pre_q.pop_front();
    end else begin
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'd27) opc = 5'd26;
      w = {opc, 27'($urandom)};
      c = 1'($urandom);
    end
  endtask

  task automatic run_prog(input int k, input int n, input int mw);
    logic [31:0] w;
    logic c;
    int left;
    bit busy, last;
    outv_t e;
    left = n; busy = 0;
    pick(w, c);
    for (int i = 0; i < 4000 && (left > 0 || busy); i++) begin
      @(negedge clock);
      if (busy) e = st_q.pop_front(); else e = '0;
      last = busy && (st_q.size() == 0);
      run_a[k] = ($urandom_range(0, 3) != 0) && (left > 0 || (busy && !last));
      ir_a[k]  = w;
      con_a[k] = c;
      #1 check_vec("trace", obs[k], e);
      if (!busy || last) begin
        if (last) pick(w, c);
        if (run_a[k] && left > 0) begin
          build(w, c, mw); left--; busy = 1;
        end else busy = 0;
      end
    end
    check_int("stream_done", left + int'(busy), 0);
  endtask

  task automatic run_halt(input int k, input int mw);
    logic [31:0] w;
    outv_t e;
    w = {5'b11011, 27'($urandom)};
    build(w, 1'b0, mw);
    @(negedge clock); run_a[k] = 1'b1; ir_a[k] = w;
    #1 check_vec("halt_idle", obs[k], '0);
    while (st_q.size() > 0) begin
      @(negedge clock); e = st_q.pop_front(); run_a[k] = 1'($urandom);
      #1 check_vec("halt_fetch", obs[k], e);
    end
    repeat (5) begin
      @(negedge clock); run_a[k] = 1'($urandom);
      e = '0; e.halted = 1'b1;
      #1 check_vec("halted", obs[k], e);
    end
    @(negedge clock); clear = 1'b0;
    #1 check_vec("halt_clear", obs[k], '0);
    @(negedge clock); clear = 1'b1; run_a[k] = 1'b0;
  endtask

  task automatic run_reset_mid(input int k, input int mw);
    logic [31:0] w;
    outv_t e;
    w = {5'b10000, 27'($urandom)};
    build(w, 1'b0, mw);
    @(negedge clock); run_a[k] = 1'b1; ir_a[k] = w;
    #1 check_vec("mid_idle", obs[k], '0);
    repeat (mw + 5) begin
      @(negedge clock); e = st_q.pop_front();
      #1 check_vec("mid_steps", obs[k], e);
    end
    clear = 1'b0;
    #1 check_vec("mid_clear", obs[k], '0);
    @(negedge clock);
    #1 check_vec("mid_clear_hold", obs[k], '0);
    clear = 1'b1; run_a[k] = 1'b0;
    st_q.delete();
  endtask

  initial begin
    int reads;
    run_a = '{1'b0, 1'b0};
    ir_a  = '{32'h0, 32'h0};
    con_a = '{1'b0, 1'b0};

    // Pin the model with hand-derived values before trusting it.
    build(32'h1A920000, 1'b0, 0);
    check_int("model_add_len", st_q.size(), 6);
    check_int("model_add_t3_rout", int'(st_q[3].rout), 32'h0004);
    check_int("model_add_t3_y", int'(st_q[3].y_en), 1);
    check_int("model_add_t4_rout", int'(st_q[4].rout), 32'h0010);
    check_int("model_add_t4_op", int'(st_q[4].op), 3);
    check_int("model_add_t5_rin", int'(st_q[5].rin), 32'h0020);
    check_int("model_add_t5_zlo", int'(st_q[5].zlowout), 1);
    build({5'b00000, 4'd3, 4'd7, 19'd0}, 1'b0, 2);
    check_int("model_ld_len", st_q.size(), 12);
    reads = 0;
    foreach (st_q[i]) reads += int'(st_q[i].read);
    check_int("model_ld_reads", reads, 6);
    check_int("model_ld_t7_rin", int'(st_q[11].rin), 32'h0008);
    build({5'b10011, 4'd6, 4'd0, 19'd5}, 1'b0, 0);
    check_int("model_br_c0_pcen", int'(st_q[6].pc_en), 0);
    build({5'b10011, 4'd6, 4'd0, 19'd5}, 1'b1, 0);
    check_int("model_br_c1_pcen", int'(st_q[6].pc_en), 1);
    check_int("model_br_c1_zlo", int'(st_q[6].zlowout), 1);

    @(negedge clock);
    #1 check_vec("reset_dut0", obs[0], '0);
    check_vec("reset_dut1", obs[1], '0);
    @(negedge clock); clear = 1'b1;

    pre_q.push_back({1'b0, 32'h1A920000});
    pre_q.push_back({1'b0, 5'b10011, 4'd6, 4'd0, 19'd5});
    pre_q.push_back({1'b1, 5'b10011, 4'd6, 4'd0, 19'd5});
    pre_q.push_back({1'b0, 5'b11111, 27'h5A5A5A5});
    pre_q.push_back({1'b0, 5'b11010, 27'h0});
    run_prog(0, 40, 0);
    run_halt(0, 0);
    run_reset_mid(0, 0);
    run_prog(0, 5, 0);

    pre_q.push_back({1'b0, 5'b00000, 4'd3, 4'd7, 19'd12});
    pre_q.push_back({1'b0, 5'b00010, 4'd9, 4'd1, 19'd4});
    run_prog(1, 30, 2);
    run_reset_mid(1, 2);
    run_prog(1, 5, 2);
    run_halt(1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle control unit that sits directly upstream of the 32-bit bus datapath and drives every datapath strobe each cycle: bus-source selects, register enables, IncPC, Read/Write and the 5-bit ALU operation. It steps through fetch, then an opcode-specific execute sequence, decoding register fields from IR through a select/encode sub-block into per-register in/out strobes.

Parameters:
MEM_WAIT, 0, extra cycles Read/MDR_enable are held for each memory read, and Write for each memory write (0..7)
NUM_REGS, 16, general-purpose registers addressed by 4-bit fields

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous, active-low reset (0 = reset)
run  in  1  level; 1 allows the next fetch to start
ir  in  32  IR_data_out from the datapath
con_ff  in  1  branch condition flip-flop output
PCout, ZLowout, ZHighout, MDRout, Cout  out  1 each  bus-source strobes
MAR_enable, Z_low_enable, Z_high_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HI_enable, LO_enable, CON_enable  out  1 each  register loads
IncPC, Read, Write, BAout  out  1 each  PC increment, memory read/write, base-address-zero bus select
operation  out  5  ALU opcode
reg_in  out  16  one-hot GPR enables R0..R15
reg_out  out  16  one-hot GPR bus-source strobes R0..R15
halted  out  1  high after HALT executes
illegal  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- IR fields: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15]; C = ir[18:0], sign-extended by the datapath.
- States: IDLE, F0, F1, F2, T3..T7, HALT. Reset: state IDLE; all outputs 0, operation = 0, halted = 0.
- IDLE -> F0 when run = 1. After an instruction's last step, go to F0 if run = 1, else IDLE. Dropping run mid-instruction never aborts it.
- Outputs are Moore (decoded from state + latched ir), with one exception: the branch PC_enable in T6 is gated by con_ff.
- F0: PCout, MAR_enable, IncPC. F1: Read, MDR_enable for MEM_WAIT+1 cycles, counted by a wait counter. F2: MDRout, IR_enable.
- R-type (add 00011, sub, and, or, ror, rol, shr, shra, shl 01011): T3 Grb Rout Y_enable; T4 Grc Rout, operation = opcode, Z_low_enable; T5 ZLowout Gra Rin.
- addi/andi/ori (01100-01110): T3 Grb Rout Y_enable; T4 Cout, operation = opcode, Z_low_enable; T5 ZLowout Gra Rin.
- ldi 00001: T3 Grb BAout Y_enable; T4 Cout, operation = ADD, Z_low_enable; T5 ZLowout Gra Rin.
- ld 00000: T3-T4 as ldi; T5 ZLowout MAR_enable; T6 Read MDR_enable (MEM_WAIT+1 cycles); T7 MDRout Gra Rin.
- st 00010: T3-T5 as ld; T6 Gra Rout MDR_enable with Read = 0; T7 Write (MEM_WAIT+1 cycles).
- div 01111 / mul 10000: T3 Gra Rout Y_enable; T4 Grb Rout, operation = opcode, Z_low_enable, Z_high_enable; T5 ZLowout LO_enable; T6 ZHighout HI_enable.
- neg 10001 / not 10010: T3 Grb Rout, operation = opcode, Z_low_enable; T4 ZLowout Gra Rin.
- branch 10011: T3 Gra Rout CON_enable; T4 PCout Y_enable; T5 Cout, operation = ADD, Z_low_enable; T6 ZLowout, PC_enable only if con_ff = 1.
- jr 10100: T3 Gra Rout PC_enable.
- nop 11010: return after F2.
- halt 11011: -> HALT; halted = 1; stays in HALT until clear.
- Any other opcode: illegal pulses for 1 cycle in T3, then treated as nop.
- Select/encode: exactly one of Gra/Grb/Grc is active per step; reg_in = Rin ? onehot(field) : 0; reg_out = (Rout | BAout) ? onehot(field) : 0. At most one bus-source strobe is high in any cycle.
- Reset mid-instruction: immediate return to IDLE; all strobes 0 within the reset assertion.

Decomposition:
- Shared package cpu_pkg: 5-bit opcode constants, state enum, IR field bit positions.
- Sub-module select_encode: combinational; takes ir, Gra/Grb/Grc, Rin/Rout/BAout and produces reg_in/reg_out.
- The sequencer holds the state register and the MEM_WAIT counter.

Test Plan:
- clear = 0 then run = 1, MEM_WAIT = 0 -> F0 on the first edge after release; F0 has PCout, MAR_enable, IncPC; F1 has Read, MDR_enable; F2 has MDRout, IR_enable.
- ir = 0x1A920000 (add R5,R2,R4) -> T3 reg_out = 0x0004 with Y_enable; T4 reg_out = 0x0010 with operation = 00011; T5 reg_in = 0x0020 with ZLowout; next state F0.
- MEM_WAIT = 2, ld instruction -> Read high for exactly 3 cycles in F1 and 3 cycles in T6; T7 has MDRout and reg_in = onehot(Ra).
- Branch with con_ff = 0, then repeat with con_ff = 1 -> T6 PC_enable = 0, then PC_enable = 1; ZLowout high in T6 both times.
- opcode 11111 -> illegal pulses 1 cycle, no reg_in/Write/PC_enable asserted, next fetch follows. Then halt 11011 -> halted = 1, stays until clear = 0.
- clear = 0 during T4 of mul -> all outputs 0 immediately; state IDLE; halted = 0.
